// File: rtl/fifo_pkg.sv
// Shared defaults for the asynchronous FIFO write-side pointer logic.
package fifo_pkg;

  // Default FIFO depth is 2**FIFO_ADDR_WIDTH entries.
  localparam int FIFO_ADDR_WIDTH   = 4;
  // Default almost-full threshold, expressed as remaining free entries.
  localparam int FIFO_AFULL_MARGIN = 2;
  // Pointers carry one extra wrap bit on top of the address bits.
  localparam int FIFO_PTR_WIDTH    = FIFO_ADDR_WIDTH + 1;

endpackage : fifo_pkg

// File: rtl/fifo_wptr_full_gray_bin.sv
// Gray-to-binary converter: binary bit i is the XOR of all Gray bits at
// position i and above, so the MSB passes straight through.
module gray_bin #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  // Reduce the shifted Gray word so each bit folds in every higher bit.
  always_comb begin
    bin_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin_o[i] = ^(gray_i >> i);
    end
  end

endmodule : gray_bin

// File: rtl/fifo_wptr_full.sv
// Write-domain half of an asynchronous FIFO: binary/Gray write pointer,
// two-flop synchronizer for the foreign read pointer, and the registered
// full / almost-full / level / overflow flags.
//
// Handshake: wr_en is a request with no valid/ready pairing beyond wr_ack.
// A write happens in a cycle exactly when wr_ack is high (wr_en & ~full);
// a request while full is dropped and reported one cycle later on overflow.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH   = FIFO_ADDR_WIDTH,
  parameter int AFULL_MARGIN = FIFO_AFULL_MARGIN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH:0]   rd_gray_async,
  output logic                  wr_ack,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH:0]   wr_gray,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  overflow
);

  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [PTR_W-1:0] AFULL_THRESH = PTR_W'(DEPTH - AFULL_MARGIN);

  logic [PTR_W-1:0]      wr_bin_q, wr_bin_d;
  logic [PTR_W-1:0]      wr_gray_q, wr_gray_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [PTR_W-1:0]      wr_level_q, wr_level_d;
  logic                  full_q, full_d;
  logic                  almost_full_q, almost_full_d;
  logic                  overflow_q, overflow_d;
  logic                  wr_ack_c;

  (* ASYNC_REG = "TRUE" *) logic [PTR_W-1:0] rd_gray_s1_q;
  (* ASYNC_REG = "TRUE" *) logic [PTR_W-1:0] rd_gray_s2_q;

  logic [PTR_W-1:0] rd_bin_s;
  logic [PTR_W-1:0] rd_gray_wrapped;

  gray_bin #(
    .WIDTH (PTR_W)
  ) u_rd_gray_bin (
    .gray_i (rd_gray_s2_q),
    .bin_o  (rd_bin_s)
  );

  // Next-state pointer and flag computation; flags look at the pointer
  // after this cycle's write so full appears right after the filling write.
  always_comb begin
    wr_ack_c        = wr_en & ~full_q & ~rst;
    wr_bin_d        = wr_bin_q + {{ADDR_WIDTH{1'b0}}, wr_ack_c};
    wr_gray_d       = (wr_bin_d >> 1) ^ wr_bin_d;
    // Full when the write pointer is exactly one lap ahead: in Gray code
    // that is the read pointer with its top two bits inverted.
    rd_gray_wrapped = {~rd_gray_s2_q[PTR_W-1:PTR_W-2], rd_gray_s2_q[PTR_W-3:0]};
    full_d          = (wr_gray_d == rd_gray_wrapped);
    wr_level_d      = wr_bin_d - rd_bin_s;
    almost_full_d   = (wr_level_d >= AFULL_THRESH);
    overflow_d      = wr_en & full_q & ~rst;
  end

  // Write pointer, address and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bin_q      <= '0;
      wr_gray_q     <= '0;
      wr_addr_q     <= '0;
      wr_level_q    <= '0;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      wr_bin_q      <= wr_bin_d;
      wr_gray_q     <= wr_gray_d;
      wr_addr_q     <= wr_bin_d[ADDR_WIDTH-1:0];
      wr_level_q    <= wr_level_d;
      full_q        <= full_d;
      almost_full_q <= almost_full_d;
      overflow_q    <= overflow_d;
    end
  end

  // Two-flop synchronizer for the foreign read pointer, no logic between stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_gray_s1_q <= '0;
      rd_gray_s2_q <= '0;
    end else begin
      rd_gray_s1_q <= rd_gray_async;
      rd_gray_s2_q <= rd_gray_s1_q;
    end
  end

  assign wr_ack      = wr_ack_c;
  assign wr_addr     = wr_addr_q;
  assign wr_gray     = wr_gray_q;
  assign full        = full_q;
  assign almost_full = almost_full_q;
  assign wr_level    = wr_level_q;
  assign overflow    = overflow_q;

endmodule : fifo_wptr_full
